// File: rtl/bioz_exc_clkgen_pkg.sv
// rtl/bioz_exc_clkgen_pkg.sv - shared types and helpers for the BioZ excitation clock generator
// Contents: FSM state enum, Fsel clamp, divide-ratio and counter-width helpers.
package bioz_clkgen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_e;

  // Counter must reach D-1 = (4 << MAX_FSEL) - 1, which needs MAX_FSEL+2 bits.
  function automatic int cnt_width(input int max_fsel);
    return max_fsel + 2;
  endfunction

  function automatic logic [3:0] clamp_fsel(input logic [3:0] fsel, input int max_fsel);
    if (int'(fsel) > max_fsel) return 4'(max_fsel);
    return fsel;
  endfunction

  function automatic logic [31:0] div_ratio(input logic [3:0] fsel, input int max_fsel);
    return 32'd4 << clamp_fsel(fsel, max_fsel);
  endfunction

endpackage

// File: rtl/bioz_exc_clkgen_if.sv
// rtl/bioz_exc_clkgen_if.sv - control inputs and excitation outputs of the clock generator
// master: controller side (drives enable/Fsel, observes outputs)
// slave : generator side (consumes enable/Fsel, drives exc_*, period_strobe, running, fsel_active)
interface bioz_exc_clkgen_if;
  logic       enable;
  logic [3:0] Fsel;
  logic       exc_i;
  logic       exc_ib;
  logic       exc_q;
  logic       period_strobe;
  logic       running;
  logic [3:0] fsel_active;

  modport master (
    output enable, Fsel,
    input  exc_i, exc_ib, exc_q, period_strobe, running, fsel_active
  );

  modport slave (
    input  enable, Fsel,
    output exc_i, exc_ib, exc_q, period_strobe, running, fsel_active
  );
endinterface

// File: rtl/bioz_exc_clkgen_sync.sv
// rtl/bioz_exc_clkgen_sync.sv - single-bit multi-flop synchronizer, resets to 0
// Ports: clk, rst (async, active-high), d_i (asynchronous input), q_o (synchronized output)
module bioz_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/bioz_exc_clkgen.sv
// rtl/bioz_exc_clkgen.sv - glitch-free, frequency-selectable I/Q excitation clock generator
// Ports: clk, rst (async, active-high), bus (slave modport: enable/Fsel in;
//        exc_i/exc_ib/exc_q/period_strobe/running/fsel_active out)
module bioz_exc_clkgen
  import bioz_clkgen_pkg::*;
#(
  parameter int MAX_FSEL    = 7,
  parameter int SYNC_STAGES = 2
) (
  input logic              clk,
  input logic              rst,
  bioz_exc_clkgen_if.slave bus
);

  localparam int CNT_W = cnt_width(MAX_FSEL);

  logic             en_sync;
  logic [3:0]       fsel_raw;
  logic [3:0]       fsel_prev_q;
  logic [3:0]       fsel_sync_q;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]       fsel_active_q, fsel_active_d;

  logic             exc_i_q, exc_i_d;
  logic             exc_ib_q, exc_ib_d;
  logic             exc_q_q, exc_q_d;
  logic             strobe_q, strobe_d;
  logic             running_q, running_d;

  logic [31:0]      ratio, cnt_ext;
  logic             wrap, active;

  bioz_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_en (
    .clk (clk),
    .rst (rst),
    .d_i (bus.enable),
    .q_o (en_sync)
  );

  for (genvar b = 0; b < 4; b++) begin : g_fsel_sync
    bioz_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_fsel (
      .clk (clk),
      .rst (rst),
      .d_i (bus.Fsel[b]),
      .q_o (fsel_raw[b])
    );
  end

  // Bits may resolve on different cycles; only accept a code seen twice in a row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsel_prev_q <= '0;
      fsel_sync_q <= '0;
    end else begin
      fsel_prev_q <= fsel_raw;
      if (fsel_raw == fsel_prev_q) fsel_sync_q <= fsel_raw;
    end
  end

  // Period length always follows fsel_active_q, which only moves at a wrap,
  // so the current period is never shortened or stretched.
  assign ratio   = div_ratio(fsel_active_q, MAX_FSEL);
  assign cnt_ext = 32'(cnt_q);
  assign wrap    = (cnt_ext == ratio - 32'd1);
  assign cnt_inc = wrap ? '0 : cnt_q + CNT_W'(1);
  assign active  = (state_q != ST_IDLE);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    fsel_active_d = fsel_active_q;
    unique case (state_q)
      ST_IDLE: begin
        if (en_sync) begin
          state_d       = ST_RUN;
          cnt_d         = '0;
          fsel_active_d = clamp_fsel(fsel_sync_q, MAX_FSEL);
        end
      end
      ST_RUN: begin
        cnt_d = cnt_inc;
        if (wrap) fsel_active_d = clamp_fsel(fsel_sync_q, MAX_FSEL);
        if (!en_sync) state_d = ST_STOPPING;
      end
      ST_STOPPING: begin
        // Counting is untouched here, so returning to RUN keeps phase.
        cnt_d = cnt_inc;
        if (en_sync)   state_d = ST_RUN;
        else if (wrap) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    exc_i_d   = active && (cnt_ext < (ratio >> 1));
    exc_ib_d  = active && !(cnt_ext < (ratio >> 1));
    exc_q_d   = active && (cnt_ext >= (ratio >> 2)) &&
                (cnt_ext < ((ratio >> 1) + (ratio >> 2)));
    strobe_d  = active && wrap;
    running_d = active;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      fsel_active_q <= '0;
      exc_i_q       <= 1'b0;
      exc_ib_q      <= 1'b0;
      exc_q_q       <= 1'b0;
      strobe_q      <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      fsel_active_q <= fsel_active_d;
      exc_i_q       <= exc_i_d;
      exc_ib_q      <= exc_ib_d;
      exc_q_q       <= exc_q_d;
      strobe_q      <= strobe_d;
      running_q     <= running_d;
    end
  end

  assign bus.exc_i         = exc_i_q;
  assign bus.exc_ib        = exc_ib_q;
  assign bus.exc_q         = exc_q_q;
  assign bus.period_strobe = strobe_q;
  assign bus.running       = running_q;
  assign bus.fsel_active   = fsel_active_q;

endmodule

// File: tb/tb_bioz_exc_clkgen.sv
// tb/tb_bioz_exc_clkgen.sv - self-checking bench for bioz_exc_clkgen
module tb_bioz_exc_clkgen;
  import bioz_clkgen_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bioz_exc_clkgen_if bus();

  bioz_exc_clkgen #(.MAX_FSEL(7), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic       en;
    logic [3:0] fsel;
    logic       i;
    logic       q;
    logic       ib;
    logic       st;
    logic       run;
    logic [3:0] fa;
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t mk(input logic en, input logic i, input logic q,
                              input logic ib, input logic st, input logic run);
    vec_t v;
    v.en = en; v.fsel = 4'd0; v.i = i; v.q = q; v.ib = ib;
    v.st = st; v.run = run; v.fa = 4'd0;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int all_outs();
    return int'({bus.exc_i, bus.exc_ib, bus.exc_q, bus.period_strobe, bus.running, bus.fsel_active});
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.Fsel = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_strobe(input string name);
    int ok;
    ok = 0;
    for (int n = 0; n < 2000; n++) begin
      @(posedge clk); @(negedge clk);
      if (bus.period_strobe) begin ok = 1; break; end
    end
    chk(name, ok, 1);
  endtask

  task automatic start_run(input logic [3:0] f, input string name);
    do_reset();
    bus.Fsel = f;
    repeat (6) @(negedge clk);
    bus.enable = 1'b1;
    wait_strobe(name);
  endtask

  // Starts right after a strobe sample (counter at 0) and ends on the next strobe sample.
  task automatic measure(input int chg_at, input logic chg_en, input logic [3:0] chg_fsel,
                         input int rel_at,
                         output int len, output int hi_i, output int hi_q, output int ib_bad,
                         output int run_low, output int fa_mid, output int saw_stop);
    len = 0; hi_i = 0; hi_q = 0; ib_bad = 0; run_low = 0; fa_mid = -1; saw_stop = 0;
    for (int n = 0; n < 2000; n++) begin
      if (n == chg_at) begin bus.enable = chg_en; bus.Fsel = chg_fsel; end
      if (n == rel_at) bus.enable = 1'b1;
      @(posedge clk); @(negedge clk);
      len++;
      if (bus.exc_i) hi_i++;
      if (bus.exc_q) hi_q++;
      if (bus.exc_ib == bus.exc_i) ib_bad++;
      if (!bus.running) run_low++;
      if (n == 7) fa_mid = int'(bus.fsel_active);
      if (dut.state_q == ST_STOPPING) saw_stop = 1;
      if (bus.period_strobe) break;
    end
  endtask

  initial begin
    int len, hi_i, hi_q, ib_bad, run_low, fa_mid, saw_stop, nz;

    vecs[0]  = mk(1, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 0, 0, 0);
    vecs[2]  = mk(1, 0, 0, 0, 0, 0);
    vecs[3]  = mk(1, 1, 0, 0, 0, 1);
    vecs[4]  = mk(1, 1, 1, 0, 0, 1);
    vecs[5]  = mk(1, 0, 1, 1, 0, 1);
    vecs[6]  = mk(1, 0, 0, 1, 1, 1);
    vecs[7]  = mk(1, 1, 0, 0, 0, 1);
    vecs[8]  = mk(1, 1, 1, 0, 0, 1);
    vecs[9]  = mk(1, 0, 1, 1, 0, 1);
    vecs[10] = mk(0, 0, 0, 1, 1, 1);
    vecs[11] = mk(0, 1, 0, 0, 0, 1);
    vecs[12] = mk(0, 1, 1, 0, 0, 1);
    vecs[13] = mk(0, 0, 1, 1, 0, 1);
    vecs[14] = mk(0, 0, 0, 1, 1, 1);
    vecs[15] = mk(0, 0, 0, 0, 0, 0);
    vecs[16] = mk(0, 0, 0, 0, 0, 0);

    rst = 1'b1;
    bus.enable = 1'b0;
    bus.Fsel = 4'd0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", all_outs(), 0);

    // Fsel=0: latency, 1100/0110 pattern, strobe every 4th, then stop.
    for (int k = 0; k < 17; k++) begin
      bus.enable = vecs[k].en;
      bus.Fsel   = vecs[k].fsel;
      @(posedge clk); @(negedge clk);
      chk($sformatf("v%0d_exc_i", k),  int'(bus.exc_i),         int'(vecs[k].i));
      chk($sformatf("v%0d_exc_q", k),  int'(bus.exc_q),         int'(vecs[k].q));
      chk($sformatf("v%0d_exc_ib", k), int'(bus.exc_ib),        int'(vecs[k].ib));
      chk($sformatf("v%0d_strobe", k), int'(bus.period_strobe), int'(vecs[k].st));
      chk($sformatf("v%0d_running", k),int'(bus.running),       int'(vecs[k].run));
      chk($sformatf("v%0d_fsel_act", k),int'(bus.fsel_active),  int'(vecs[k].fa));
    end

    // Frequency switch 2 -> 1 at cnt=5.
    start_run(4'd2, "fs_first_strobe");
    measure(5, 1'b1, 4'd1, -1, len, hi_i, hi_q, ib_bad, run_low, fa_mid, saw_stop);
    chk("fs_cur_len", len, 16);
    chk("fs_cur_hi_i", hi_i, 8);
    chk("fs_cur_hi_q", hi_q, 8);
    chk("fs_cur_ib", ib_bad, 0);
    chk("fs_fa_mid", fa_mid, 2);
    chk("fs_fa_after_wrap", int'(bus.fsel_active), 1);
    measure(-1, 1'b1, 4'd1, -1, len, hi_i, hi_q, ib_bad, run_low, fa_mid, saw_stop);
    chk("fs_next_len", len, 8);
    chk("fs_next_hi_i", hi_i, 4);
    chk("fs_next_hi_q", hi_q, 4);

    // Stop: enable low at cnt=3, D=16.
    start_run(4'd2, "stop_first_strobe");
    measure(3, 1'b0, 4'd2, -1, len, hi_i, hi_q, ib_bad, run_low, fa_mid, saw_stop);
    chk("stop_len", len, 16);
    chk("stop_hi_i", hi_i, 8);
    chk("stop_run_low", run_low, 0);
    chk("stop_saw_stopping", saw_stop, 1);
    @(posedge clk); @(negedge clk);
    chk("stop_running_fall", int'(bus.running), 0);
    chk("stop_exc_i_idle", int'(bus.exc_i), 0);
    nz = 0;
    repeat (5) begin
      @(posedge clk); @(negedge clk);
      if ({bus.exc_i, bus.exc_ib, bus.exc_q, bus.period_strobe, bus.running} != 5'b0) nz++;
    end
    chk("stop_stays_idle", nz, 0);

    // Short enable drop of 2 cycles.
    start_run(4'd2, "drop_first_strobe");
    measure(3, 1'b0, 4'd2, 5, len, hi_i, hi_q, ib_bad, run_low, fa_mid, saw_stop);
    chk("drop_len", len, 16);
    chk("drop_hi_i", hi_i, 8);
    chk("drop_run_low", run_low, 0);
    chk("drop_saw_stopping", saw_stop, 1);
    measure(-1, 1'b1, 4'd2, -1, len, hi_i, hi_q, ib_bad, run_low, fa_mid, saw_stop);
    chk("drop_next_len", len, 16);
    chk("drop_next_run_low", run_low, 0);
    chk("drop_back_in_run", saw_stop, 0);

    // Clamp: Fsel=15 behaves as 7.
    start_run(4'd15, "clamp_first_strobe");
    chk("clamp_fsel_active", int'(bus.fsel_active), 7);
    measure(-1, 1'b1, 4'd15, -1, len, hi_i, hi_q, ib_bad, run_low, fa_mid, saw_stop);
    chk("clamp_len", len, 512);
    chk("clamp_hi_i", hi_i, 256);
    chk("clamp_hi_q", hi_q, 256);

    // Asynchronous reset mid-run with Fsel=3.
    start_run(4'd3, "rst_first_strobe");
    repeat (5) @(negedge clk);
    chk("rst_running_before", int'(bus.running), 1);
    #2 rst = 1'b1;
    #1 chk("rst_async_clear", all_outs(), 0);
    bus.enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    nz = 0;
    repeat (20) begin
      @(posedge clk); @(negedge clk);
      if (all_outs() != 0) nz++;
    end
    chk("rst_stays_idle", nz, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
